// File: rtl/out_port_bank_if.sv
// Core-side bus of the output latch bank: decode strobes in,
// latch/mask state and bit readback out.
interface out_port_bank_if #(
    parameter int NUM_PORTS = 2,
    parameter int WIDTH     = 8
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BW = $clog2(WIDTH);

    logic                       ce;
    logic                       write;
    logic                       cfg_write;
    logic                       write_disable;
    logic [1:0]                 op;
    logic [PW-1:0]              port_sel;
    logic [BW-1:0]              bit_addr;
    logic                       data;
    logic [WIDTH-1:0]           cfg_data;
    logic [NUM_PORTS*WIDTH-1:0] out_latch;
    logic [NUM_PORTS*WIDTH-1:0] pulse_mask;
    logic                       rd_bit;

    modport master (
        output ce, write, cfg_write, write_disable,
        output op, port_sel, bit_addr, data, cfg_data,
        input  out_latch, pulse_mask, rd_bit
    );

    modport slave (
        input  ce, write, cfg_write, write_disable,
        input  op, port_sel, bit_addr, data, cfg_data,
        output out_latch, pulse_mask, rd_bit
    );
endinterface

// File: rtl/out_port_bank.sv
// Bank of bit-addressable output latches with set/clear/toggle,
// per-bit auto-clearing pulse mode and registered bit readback.
module out_port_bank #(
    parameter int NUM_PORTS = 2,
    parameter int WIDTH     = 8,
    parameter int PULSE_LEN = 4
) (
    input  logic           clk,
    input  logic           rst,
    out_port_bank_if.slave bus
);
    localparam int N  = NUM_PORTS * WIDTH;
    localparam int CW = $clog2(PULSE_LEN + 1);

    logic [N-1:0]  latch_q;
    logic [N-1:0]  mask_q;
    logic [CW-1:0] cnt_q [N];
    logic          rd_q;

    int   sel;
    int   psel;
    logic port_ok;
    logic addr_ok;
    logic wr_ok;
    logic cfg_ok;
    logic cur;
    logic nxt;

    always_comb begin
        psel    = int'(bus.port_sel);
        port_ok = psel < NUM_PORTS;
        addr_ok = port_ok && (int'(bus.bit_addr) < WIDTH);
        sel     = psel * WIDTH + int'(bus.bit_addr);
        wr_ok   = bus.ce & bus.write & ~bus.write_disable & addr_ok;
        cfg_ok  = bus.ce & bus.cfg_write & ~bus.write_disable & port_ok;
        cur     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (addr_ok && i == sel) cur = latch_q[i];
        end
        case (bus.op)
            2'b00:   nxt = bus.data;
            2'b01:   nxt = 1'b1;
            2'b10:   nxt = 1'b0;
            default: nxt = ~cur;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            latch_q <= '0;
            mask_q  <= '0;
            rd_q    <= 1'b0;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            rd_q <= cur;
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int b = 0; b < WIDTH; b++) begin
                    // a data write wins over an expiring counter
                    if (wr_ok && (p * WIDTH + b) == sel) begin
                        latch_q[p*WIDTH+b] <= nxt;
                        cnt_q[p*WIDTH+b]   <= (mask_q[p*WIDTH+b] && nxt)
                                              ? CW'(PULSE_LEN) : '0;
                    end else if (cnt_q[p*WIDTH+b] == CW'(1)) begin
                        latch_q[p*WIDTH+b] <= 1'b0;
                        cnt_q[p*WIDTH+b]   <= '0;
                    end else if (cnt_q[p*WIDTH+b] != '0) begin
                        cnt_q[p*WIDTH+b] <= cnt_q[p*WIDTH+b] - CW'(1);
                    end
                    // dropping a mask bit freezes the bit as a plain latch
                    if (cfg_ok && p == psel && !bus.cfg_data[b]) begin
                        cnt_q[p*WIDTH+b] <= '0;
                    end
                end
                if (cfg_ok && p == psel) begin
                    mask_q[p*WIDTH +: WIDTH] <= bus.cfg_data;
                end
            end
        end
    end

    assign bus.out_latch  = latch_q;
    assign bus.pulse_mask = mask_q;
    assign bus.rd_bit     = rd_q;
endmodule

// File: tb/tb_out_port_bank.sv
// Directed and random checks of out_port_bank against a
// deadline-based behavioural model.
module tb_out_port_bank;
    localparam int NP = 3;
    localparam int W  = 8;
    localparam int PL = 4;
    localparam int NB = NP * W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    out_port_bank_if #(.NUM_PORTS(NP), .WIDTH(W)) bi ();

    out_port_bank #(
        .NUM_PORTS(NP),
        .WIDTH(W),
        .PULSE_LEN(PL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bi)
    );

    int total = 0;
    int bad   = 0;
    bit lat [NB];
    bit msk [NB];
    int dl  [NB];
    int now = 0;
    bit rd_m = 1'b0;
    int last_ps = 0;
    int last_ba = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Bit value plus the absolute edge at which a pulse ends.
    task automatic model_edge();
        bit nl [NB];
        int ps;
        int ba;
        int k;
        bit v;
        ps = int'(bi.port_sel);
        ba = int'(bi.bit_addr);
        for (int i = 0; i < NB; i++) nl[i] = lat[i];
        rd_m = (ps < NP && ba < W) ? lat[ps*W+ba] : 1'b0;
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                nl[i]  = 1'b0;
                msk[i] = 1'b0;
                dl[i]  = -1;
            end
            rd_m = 1'b0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (dl[i] == now) begin
                    nl[i] = 1'b0;
                    dl[i] = -1;
                end
            end
            if (bi.ce && bi.write && !bi.write_disable && ps < NP && ba < W) begin
                k = ps * W + ba;
                case (bi.op)
                    2'd0:    v = bi.data;
                    2'd1:    v = 1'b1;
                    2'd2:    v = 1'b0;
                    default: v = !lat[k];
                endcase
                nl[k] = v;
                dl[k] = (msk[k] && v) ? now + PL : -1;
            end
            if (bi.ce && bi.cfg_write && !bi.write_disable && ps < NP) begin
                for (int b = 0; b < W; b++) begin
                    msk[ps*W+b] = bi.cfg_data[b];
                    if (!bi.cfg_data[b]) dl[ps*W+b] = -1;
                end
            end
        end
        for (int i = 0; i < NB; i++) lat[i] = nl[i];
        now++;
    endtask

    task automatic check_all(input string tag);
        logic [NB-1:0] el;
        logic [NB-1:0] em;
        for (int i = 0; i < NB; i++) begin
            el[i] = lat[i];
            em[i] = msk[i];
        end
        chk({tag, ".latch"}, 64'(bi.out_latch), 64'(el));
        chk({tag, ".mask"}, 64'(bi.pulse_mask), 64'(em));
        chk({tag, ".rd"}, 64'(bi.rd_bit), 64'(rd_m));
    endtask

    task automatic step(input bit r, input bit c, input bit w,
                        input bit cw, input bit wd, input logic [1:0] o,
                        input int ps, input int ba, input bit d,
                        input logic [7:0] cd, input string tag);
        rst              = r;
        bi.ce            = c;
        bi.write         = w;
        bi.cfg_write     = cw;
        bi.write_disable = wd;
        bi.op            = o;
        bi.port_sel      = ps[1:0];
        bi.bit_addr      = ba[2:0];
        bi.data          = d;
        bi.cfg_data      = cd;
        last_ps          = ps;
        last_ba          = ba;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic wr(input logic [1:0] o, input int ps, input int ba,
                      input bit d, input string tag);
        step(0, 1, 1, 0, 0, o, ps, ba, d, 8'h00, tag);
    endtask

    task automatic cfg(input int ps, input logic [7:0] cd,
                       input string tag);
        step(0, 1, 0, 1, 0, 2'd0, ps, 0, 0, cd, tag);
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 2'd0, last_ps, last_ba, 0, 8'h00, tag);
    endtask

    int hi;

    initial begin
        for (int i = 0; i < NB; i++) dl[i] = -1;
        bi.ce = 0; bi.write = 0; bi.cfg_write = 0; bi.write_disable = 0;
        bi.op = 0; bi.port_sel = 0; bi.bit_addr = 0; bi.data = 0;
        bi.cfg_data = 0;

        step(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 8'h00, "rst");
        chk("rst_latch0", 64'(bi.out_latch), 64'h0);
        chk("rst_rd0", 64'(bi.rd_bit), 64'h0);

        wr(2'd1, 1, 5, 0, "set_p1b5");
        chk("set_p1b5_const", 64'(bi.out_latch), 64'h002000);
        wr(2'd3, 1, 5, 0, "tog_p1b5");
        chk("tog_p1b5_const", 64'(bi.out_latch), 64'h000000);
        wr(2'd0, 0, 7, 1, "wr_p0b7");
        chk("wr_p0b7_const", 64'(bi.out_latch), 64'h000080);

        step(0, 1, 1, 1, 1, 2'd1, 0, 0, 0, 8'hff, "wdis");
        chk("wdis_const", 64'(bi.pulse_mask), 64'h0);
        step(0, 0, 1, 1, 0, 2'd1, 0, 0, 0, 8'hff, "ce0");
        chk("ce0_const", 64'(bi.out_latch), 64'h000080);

        cfg(0, 8'h01, "cfg01");
        wr(2'd1, 0, 0, 0, "pset");
        hi = int'(bi.out_latch[0]);
        for (int i = 0; i < 6; i++) begin
            idle("pulse");
            hi += int'(bi.out_latch[0]);
        end
        chk("pulse_len", 64'(hi), 64'(PL));

        wr(2'd1, 0, 0, 0, "rt_set");
        idle("rt_mid");
        wr(2'd1, 0, 0, 0, "rt_again");
        hi = int'(bi.out_latch[0]);
        for (int i = 0; i < 6; i++) begin
            idle("rt");
            hi += int'(bi.out_latch[0]);
        end
        chk("retrig_len", 64'(hi), 64'(PL));

        wr(2'd1, 0, 0, 0, "clr_set");
        idle("clr_mid");
        wr(2'd2, 0, 0, 0, "clr_op");
        for (int i = 0; i < 5; i++) idle("clr_after");

        wr(2'd1, 0, 0, 0, "unm_set");
        idle("unm_mid");
        cfg(0, 8'h00, "unm_cfg");
        for (int i = 0; i < 6; i++) idle("unm_after");
        chk("unmask_hold", 64'(bi.out_latch[0]), 64'h1);

        step(0, 1, 1, 1, 0, 2'd1, 0, 3, 0, 8'h08, "same_cyc");
        for (int i = 0; i < 6; i++) idle("same_after");
        chk("same_plain", 64'(bi.out_latch[3]), 64'h1);

        cfg(0, 8'h01, "rp_cfg");
        wr(2'd1, 0, 0, 0, "rp_set");
        idle("rp_mid");
        step(1, 1, 1, 1, 0, 2'd1, 1, 1, 0, 8'hff, "rst_mid");
        chk("rst_mid_const", 64'(bi.out_latch), 64'h0);
        for (int i = 0; i < 5; i++) idle("rst_after");

        wr(2'd1, 2, 6, 0, "rb_set");
        idle("rb_read");
        chk("rb_const", 64'(bi.rd_bit), 64'h1);
        wr(2'd1, 3, 2, 0, "oor_wr");
        idle("oor_read");
        chk("oor_rd0", 64'(bi.rd_bit), 64'h0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0),
                 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)),
                 "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/out_port_bank.md
# out_port_bank

Parametrised bank of bit-addressable output latches for the microprocessor's external output pins. It generalises the single 8-bit serial-write output latch to NUM_PORTS ports of WIDTH bits. It adds set/clear/toggle operations, a per-bit auto-clearing pulse mode driven by per-bit counters, and a registered bit readback. It sits between the core's I/O decode (ce/write/address) and the top-level output pins.

## Interface
- NUM_PORTS, 2, number of output ports (>=1)
- WIDTH, 8, bits per port (>=2)
- PULSE_LEN, 4, cycles a pulse-mode bit stays high after being set (>=1)
- PW = max(1, clog2(NUM_PORTS)), BW = clog2(WIDTH) (derived localparams)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ce  in  1  chip enable for this block
- write  in  1  data-write strobe
- cfg_write  in  1  pulse-mask write strobe
- write_disable  in  1  global write lock; blocks both write and cfg_write
- op  in  2  00 write data, 01 set, 10 clear, 11 toggle
- port_sel  in  PW  target port
- bit_addr  in  BW  target bit within port
- data  in  1  bit value for op=00
- cfg_data  in  WIDTH  new pulse mask for port_sel
- out_latch  out  NUM_PORTS*WIDTH  port p occupies bits [p*WIDTH +: WIDTH]
- pulse_mask  out  NUM_PORTS*WIDTH  current pulse-mode mask, same packing
- rd_bit  out  1  registered out_latch[port_sel][bit_addr]

## Operation
- Data write is accepted when ce & write & ~write_disable, port_sel < NUM_PORTS, and bit_addr < WIDTH. Otherwise it is ignored with no state change.
- Only the addressed bit changes: op 00 -> data; 01 -> 1; 10 -> 0; 11 -> ~current.
- A config write is accepted when ce & cfg_write & ~write_disable and port_sel is in range. It replaces the whole pulse mask of port_sel with cfg_data.
- Each bit has a down-counter cnt of clog2(PULSE_LEN+1) bits; its reset value is 0.
- Pulse mode applies to a bit whose mask is 1 at the time of the write:
  - A write that leaves the bit at 1 (op 00 with data=1, op 01, or op 11 from 0) loads cnt=PULSE_LEN. This also retriggers a pulse already in progress.
  - A write that leaves the bit at 0 clears it immediately and sets cnt=0.
- Each cycle with cnt>1, cnt decrements. When cnt==1, the next edge clears the bit and sets cnt=0.
- A bit whose mask is 0 is a plain latch and its cnt is held at 0.
- A config write that clears a mask bit forces that bit's cnt to 0; the bit keeps its current value. Setting a mask bit does not start a pulse on a bit that is already 1.
- Simultaneous data write and config write are both accepted. The data write's pulse decision uses the mask value from before the update.
- A data write to a bit on the same edge its counter expires takes the data write's result.
- rd_bit samples every cycle regardless of ce, using the pre-edge out_latch value. Out-of-range addresses read 0.
- No cross-bit or cross-port interaction; all ports update in parallel.

## Timing
- Reset (rst=1 at an edge) sets out_latch=0, pulse_mask=0, all cnt=0, and rd_bit=0. Reset overrides any simultaneous write or config write.
- Reset asserted mid-pulse aborts the pulse; the bit reads 0 on the following cycle.
- Write latency is 1 cycle: the value is visible on out_latch after the accepting edge.
- Pulse-mode set: the bit is high for exactly PULSE_LEN cycles after the setting edge, then 0.
- Readback latency is 1 cycle after the address is presented. A write in cycle N to the same address is reflected in rd_bit after the edge ending cycle N+1.
- write_disable is sampled in the same cycle as the strobe; there is no queuing of blocked writes.

## Test plan
- Reset, then op=01 at port 1, bit 5 (defaults) -> out_latch = 0x2000. Then op=11 on the same bit -> out_latch = 0x0000. Then op=00 with data=1 on port 0, bit 7 -> 0x0080.
- write_disable=1 with ce, write, op=01, and also cfg_write -> out_latch and pulse_mask unchanged. With ce=0 -> unchanged.
- cfg_write port 0 with cfg_data=0x01, then op=01 on bit 0 -> bit 0 high for exactly 4 cycles then 0. op=01 again at cycle 2 of the pulse -> the high time extends to 4 cycles from the retrigger edge.
- During a pulse, op=10 on the pulsing bit -> it clears the next cycle and no further toggling occurs. In a separate run, clear the mask mid-pulse -> the bit stays 1 indefinitely.
- Same cycle: cfg_write sets mask bit 3 and op=01 on bit 3 -> the bit latches as plain, with no auto-clear.
- rst asserted during a pulse and during a write -> all outputs 0 the next cycle. Then check rd_bit readback of a set bit -> 1 exactly one cycle after address presentation. An out-of-range port_sel with NUM_PORTS=3 -> write ignored and rd_bit=0.
